// File: rtl/konami_lb_sched.sv
// Ping-pong scheduler for the A/B sprite line buffer: scan-out, clear-after-read, writer arbitration, bank swap.
// Clear-after-read (and pix_en spacing check) enabled by defining KONAMI_LB_SCAN_CLEAR_EN.
module konami_lb_sched #(
  parameter int PIX_W    = 4,
  parameter int ADDR_W   = 8,
  parameter int LINE_LEN = 256
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              line_start,
  input  logic              pix_en,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ack,
  output logic              bank_sel,
  output logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rd,
  output logic              disp_we,
  input  logic [PIX_W-1:0]  disp_rdata,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              wb_we,
  output logic [PIX_W-1:0]  wb_wdata,
  output logic [PIX_W-1:0]  cc,
  output logic              zero,
  output logic              err
);

  // state | meaning
  // IDLE  | waiting for line_start (or a queued one)
  // SCAN  | issuing display reads on pix_en
  // DRAIN | last read in flight, its clear follows
  // SWAP  | writer stalled, bank_sel toggles at end of this clk
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, SWAP} state_t;

`ifdef KONAMI_LB_SCAN_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(LINE_LEN - 1);

  state_t           state;
  logic             pending;
  logic [CNT_W-1:0] pix_cnt;
  logic             rd_d;
  logic             in_line;
  logic             clear_slot;
  logic             rd_go;
  logic             spacing_err;
  logic             overrun;

  assign in_line     = (state == SCAN) || (state == DRAIN);
  // A registered disp_rd means this clk is the clear slot for that address.
  assign clear_slot  = CLEAR_EN && disp_rd;
  assign rd_go       = (state == SCAN) && pix_en && !clear_slot;
  assign spacing_err = in_line && pix_en && clear_slot;
  assign overrun     = in_line && line_start;

  assign wr_ack = wr_req && (state != SWAP);
  assign zero   = (cc == '0);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      pending   <= 1'b0;
      pix_cnt   <= '0;
      rd_d      <= 1'b0;
      bank_sel  <= 1'b0;
      disp_addr <= '0;
      disp_rd   <= 1'b0;
      disp_we   <= 1'b0;
      cc        <= '0;
      err       <= 1'b0;
      wb_addr   <= '0;
      wb_we     <= 1'b0;
      wb_wdata  <= '0;
    end else begin
      disp_rd <= rd_go;
      disp_we <= clear_slot;
      rd_d    <= disp_rd;

      if (rd_go) begin
        disp_addr <= pix_cnt[ADDR_W-1:0];
        pix_cnt   <= pix_cnt + 1'b1;
      end

      // Read data arrives one clk after the strobe, whatever state we are in by then.
      if (rd_d) cc <= disp_rdata;

      if (spacing_err || overrun) err <= 1'b1;

      // Transparent (zero) pixels are acknowledged but never written.
      wb_we <= wr_ack && (wr_data != '0);
      if (wr_ack && (wr_data != '0)) begin
        wb_addr  <= wr_addr;
        wb_wdata <= wr_data;
      end

      case (state)
        IDLE: begin
          if (line_start || pending) begin
            state   <= SCAN;
            pending <= 1'b0;
            pix_cnt <= '0;
          end
        end
        SCAN: begin
          if (line_start) begin
            state   <= SWAP;
            pending <= 1'b1;
          end else if (rd_go && (pix_cnt == LAST_PIX)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          state <= SWAP;
          if (line_start) pending <= 1'b1;
        end
        SWAP: begin
          bank_sel <= ~bank_sel;
          state    <= IDLE;
          if (line_start) pending <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_konami_lb_sched.sv
// Directed bench for konami_lb_sched: scan/cc latency, bank swap, writer stall, overrun, pix_en spacing.
module tb_konami_lb_sched;

  logic       clk = 1'b0;
  logic       nReset;
  logic       line_start;
  logic       pix_en;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_ack;
  logic       bank_sel;
  logic [7:0] disp_addr;
  logic       disp_rd;
  logic       disp_we;
  logic [3:0] disp_rdata = 4'h0;
  logic [7:0] wb_addr;
  logic       wb_we;
  logic [3:0] wb_wdata;
  logic [3:0] cc;
  logic       zero;
  logic       err;

  int vectors = 0;
  int miscompares = 0;

`ifdef KONAMI_LB_SCAN_CLEAR_EN
  localparam bit EXP_CLR = 1'b1;
`else
  localparam bit EXP_CLR = 1'b0;
`endif

  konami_lb_sched dut (
    .clk(clk), .nReset(nReset), .line_start(line_start), .pix_en(pix_en),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .bank_sel(bank_sel), .disp_addr(disp_addr), .disp_rd(disp_rd), .disp_we(disp_we),
    .disp_rdata(disp_rdata), .wb_addr(wb_addr), .wb_we(wb_we), .wb_wdata(wb_wdata),
    .cc(cc), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  // Display bank model: data = address low nibble, valid one clk after the read strobe.
  always @(posedge clk) if (disp_rd) disp_rdata <= disp_addr[3:0];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int e;
    logic [31:0] exp_b2b;
    logic [7:0]  exp_next_addr;

    nReset = 1'b0; line_start = 1'b0; pix_en = 1'b0;
    wr_req = 1'b0; wr_addr = 8'h00; wr_data = 4'h0;
    #12;
    chk("reset_outs", {bank_sel, cc, zero, err, disp_rd, disp_we, wb_we, wr_ack},
        {1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset_addrs", {disp_addr, wb_addr, wb_wdata}, {8'h00, 8'h00, 4'h0});
    nReset = 1'b1;
    tick;

    // Writer: non-zero data written, zero data acked but not written.
    wr_req = 1'b1; wr_addr = 8'h10; wr_data = 4'h7; #1;
    chk("ack_nz", wr_ack, 1);
    tick;
    chk("write_nz", {wb_we, wb_addr, wb_wdata}, {1'b1, 8'h10, 4'h7});
    wr_data = 4'h0; #1;
    chk("ack_zero", wr_ack, 1);
    tick;
    chk("write_zero", {wb_we, wb_addr}, {1'b0, 8'h10});
    wr_req = 1'b0;

    // Line 1: full scan of bank A, pix_en every 2 clks.
    line_start = 1'b1; tick; line_start = 1'b0;
    chk("scan_entry", disp_rd, 0);
    for (int k = 0; k < 256; k++) begin
      pix_en = 1'b1; tick;
      chk("l1_read", {disp_rd, disp_addr}, {1'b1, 8'(k)});
      if (k > 0) begin
        e = (k - 1) % 16;
        chk("l1_cc", {zero, cc}, {(e == 0), e[3:0]});
      end
      pix_en = 1'b0; tick;
      chk("l1_clear", {disp_rd, disp_we, bank_sel, disp_addr}, {1'b0, EXP_CLR, 1'b0, 8'(k)});
    end

    // Now in SWAP: writer held across it.
    wr_req = 1'b1; wr_addr = 8'h20; wr_data = 4'h5; #1;
    chk("swap_ack", wr_ack, 0);
    chk("swap_bank", bank_sel, 0);
    tick;
    chk("post_swap_bank", bank_sel, 1);
    chk("cc_last", {zero, cc}, {1'b0, 4'hF});
    chk("swap_no_we", wb_we, 0);
    chk("ack_after_swap", wr_ack, 1);
    tick;
    chk("stalled_write", {wb_we, wb_addr, wb_wdata}, {1'b1, 8'h20, 4'h5});
    wr_req = 1'b0;
    chk("err_clean", err, 0);

    // Line 2 on bank B, overrun at pixel 100.
    line_start = 1'b1; tick; line_start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      pix_en = 1'b1; tick;
      chk("l2_read", {bank_sel, disp_rd, disp_addr}, {1'b1, 1'b1, 8'(k)});
      pix_en = 1'b0; tick;
    end
    line_start = 1'b1; tick; line_start = 1'b0;
    chk("overrun_err", err, 1);
    chk("cc_99", cc, 3);
    chk("overrun_bank", bank_sel, 1);
    tick;
    chk("overrun_swap", bank_sel, 0);
    tick;
    pix_en = 1'b1; tick;
    chk("restart_addr", {disp_rd, disp_addr}, {1'b1, 8'h00});
    pix_en = 1'b0; tick; tick;
    chk("restart_cc", {zero, cc}, {1'b1, 4'h0});
    pix_en = 1'b1; tick; pix_en = 1'b0;

    // Reset mid-line clears everything including sticky err.
    nReset = 1'b0; #2;
    chk("midline_reset", {bank_sel, err, zero, disp_rd, disp_we, wb_we, disp_addr},
        {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    nReset = 1'b1;

    // Back-to-back pix_en.
    line_start = 1'b1; tick; line_start = 1'b0;
    pix_en = 1'b1; tick;
    chk("b2b_first", {disp_rd, disp_addr}, {1'b1, 8'h00});
    tick;
`ifdef KONAMI_LB_SCAN_CLEAR_EN
    exp_b2b = {1'b0, 1'b1, 8'h00, 1'b1};
    exp_next_addr = 8'h01;
`else
    exp_b2b = {1'b1, 1'b0, 8'h01, 1'b0};
    exp_next_addr = 8'h02;
`endif
    chk("b2b_second", {disp_rd, disp_we, disp_addr, err}, exp_b2b);
    pix_en = 1'b0; tick;
    pix_en = 1'b1; tick;
    chk("b2b_next_addr", {disp_rd, disp_addr}, {1'b1, exp_next_addr});
    pix_en = 1'b0; tick; tick;
    chk("b2b_err_final", err, {31'd0, EXP_CLR});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
